// File: rtl/if_bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
// Holds the in-flight entry layout and counter arithmetic.
package if_bp_pkg;

   localparam int PM_STATIC  = 0;
   localparam int PM_COUNTER = 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imme;
      logic        pred_taken;
      logic        hit;
   } pend_entry_t;

   function automatic logic [31:0] weak_t(input int w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic logic [31:0] cnt_max(input int w);
      return 32'hFFFF_FFFF >> (32 - w);
   endfunction

   function automatic logic [31:0] cnt_inc(input logic [31:0] c,
                                           input int w);
      return (c == cnt_max(w)) ? c : c + 32'd1;
   endfunction

   function automatic logic [31:0] cnt_dec(input logic [31:0] c);
      return (c == 32'd0) ? c : c - 32'd1;
   endfunction

endpackage

// File: rtl/if_bp_pend_fifo.sv
// In-flight prediction FIFO: in-order push/pop with full flush.
// Flush wins over a same-cycle push.
module if_bp_pend_fifo
   import if_bp_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_push,
   input  pend_entry_t           i_data,
   input  logic                  i_pop,
   input  logic                  i_flush,
   output pend_entry_t           o_head,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   pend_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W:0]   r_cnt;

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == (PTR_W+1)'(DEPTH));
   assign o_count   = r_cnt;
   assign o_head    = r_mem[r_rd];
   assign w_do_pop  = i_pop & ~i_flush & ~o_empty;
   assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

   // pointers and occupancy; flush drops every entry at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PTR_W'(1);
         if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // entry storage, written at the tail on an accepted push
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

endmodule

// File: rtl/if_branch_predictor.sv
// Fetch-side branch predictor: tagged counter table + in-flight FIFO.
// ID pushes predictions, EX pops them in order and trains.
module if_branch_predictor
   import if_bp_pkg::*;
#(
   parameter int IDX_W      = 10,
   parameter int CNT_W      = 2,
   parameter int PEND_DEPTH = 4,
   parameter int PRED_MODE  = PM_COUNTER,
   parameter bit MISS_TAKEN = 1'b1
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         lu_valid,
   input  logic [31:0]                  lu_pc,
   input  logic [31:0]                  lu_imme,
   output logic                         lu_ready,
   output logic                         pred_taken,
   output logic [31:0]                  pred_target,
   output logic                         pred_hit,
   input  logic                         rs_valid,
   input  logic                         rs_taken,
   output logic                         mispredict,
   output logic [31:0]                  redirect_pc,
   output logic [$clog2(PEND_DEPTH):0]  pend_count,
   output logic                         err_underflow
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 30 - IDX_W;

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag [ENTRIES];
   logic [CNT_W-1:0]   r_cnt [ENTRIES];
   logic               r_mis;
   logic [31:0]        r_redir;
   logic               r_err;

   logic [IDX_W-1:0] w_lu_idx;
   logic [IDX_W-1:0] w_up_idx;
   logic             w_lu_hit;
   logic             w_lu_taken;
   logic             w_up_hit;
   logic [CNT_W-1:0] w_up_cnt;
   logic [CNT_W-1:0] w_up_next;
   logic             w_pop;
   logic             w_mis;
   logic             w_push;
   logic             w_train;
   logic             w_empty;
   logic             w_full;
   logic             w_unused_hit;
   pend_entry_t      w_head;
   pend_entry_t      w_new;

   assign w_lu_idx   = lu_pc[IDX_W+1:2];
   assign w_lu_hit   = r_valid[w_lu_idx] &&
                       (r_tag[w_lu_idx] == lu_pc[31:IDX_W+2]);
   assign w_lu_taken = (PRED_MODE == PM_COUNTER && w_lu_hit) ?
                       r_cnt[w_lu_idx][CNT_W-1] : MISS_TAKEN;

   assign pred_hit    = w_lu_hit;
   assign pred_taken  = w_lu_taken;
   assign pred_target = w_lu_taken ? lu_pc + lu_imme : lu_pc + 32'd4;

   assign w_pop   = rs_valid & ~w_empty;
   assign w_mis   = w_pop & (rs_taken != w_head.pred_taken);
   assign w_train = w_pop && (PRED_MODE == PM_COUNTER);

   // a full FIFO still accepts a push when the head leaves cleanly
   assign lu_ready = ~w_full | (w_pop & ~w_mis);
   assign w_push   = lu_valid & lu_ready;

   assign w_new.pc         = lu_pc;
   assign w_new.imme       = lu_imme;
   assign w_new.pred_taken = w_lu_taken;
   assign w_new.hit        = w_lu_hit;

   // training re-checks the table instead of trusting the stored hit
   assign w_up_idx     = w_head.pc[IDX_W+1:2];
   assign w_up_hit     = r_valid[w_up_idx] &&
                         (r_tag[w_up_idx] == w_head.pc[31:IDX_W+2]);
   assign w_up_cnt     = r_cnt[w_up_idx];
   assign w_unused_hit = w_head.hit;

   assign mispredict    = r_mis;
   assign redirect_pc   = r_redir;
   assign err_underflow = r_err;

   if_bp_pend_fifo #(
      .DEPTH (PEND_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_new),
      .i_pop   (w_pop),
      .i_flush (w_mis),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (pend_count)
   );

   // next counter value: saturate on hit, weak state on allocate
   always_comb begin
      w_up_next = w_up_cnt;
      if (!w_up_hit) begin
         w_up_next = rs_taken ? CNT_W'(weak_t(CNT_W)) :
                                CNT_W'(weak_t(CNT_W) - 32'd1);
      end else if (rs_taken) begin
         w_up_next = CNT_W'(cnt_inc(32'(w_up_cnt), CNT_W));
      end else begin
         w_up_next = CNT_W'(cnt_dec(32'(w_up_cnt)));
      end
   end

   // valid bits: cleared on reset, set whenever an entry is trained
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
      end else if (w_train) begin
         r_valid[w_up_idx] <= 1'b1;
      end
   end

   // tag and counter payload, only meaningful behind a valid bit
   always_ff @(posedge clk) begin
      if (w_train) begin
         r_tag[w_up_idx] <= w_head.pc[31:IDX_W+2];
         r_cnt[w_up_idx] <= w_up_next;
      end
   end

   // redirect pulse and sticky underflow flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mis   <= 1'b0;
         r_redir <= '0;
         r_err   <= 1'b0;
      end else begin
         r_mis <= w_mis;
         if (w_mis) begin
            r_redir <= rs_taken ? w_head.pc + w_head.imme :
                                  w_head.pc + 32'd4;
         end
         if (rs_valid && w_empty) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_branch_predictor.sv
// Bench for if_branch_predictor: directed scenarios + random traffic
// against a queue/array reference model.
module tb_if_branch_predictor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        lu_valid;
   logic [31:0] lu_pc;
   logic [31:0] lu_imme;
   logic        rs_valid;
   logic        rs_taken;

   logic        lu_ready, pred_taken, pred_hit, mispredict, err_underflow;
   logic [31:0] pred_target, redirect_pc;
   logic [2:0]  pend_count;

   logic        lu_ready_s, pred_taken_s, pred_hit_s, mispredict_s;
   logic        err_underflow_s;
   logic [31:0] pred_target_s, redirect_pc_s;
   logic [2:0]  pend_count_s;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      bit          pt;
   } ent_t;

   ent_t        m_q[$];
   bit          m_v   [1024];
   int unsigned m_tag [1024];
   int          m_c   [1024];
   bit          m_err;
   bit          e_mis;
   logic [31:0] e_red;

   always #5 clk = ~clk;

   if_branch_predictor dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .lu_valid      (lu_valid),
      .lu_pc         (lu_pc),
      .lu_imme       (lu_imme),
      .lu_ready      (lu_ready),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_hit      (pred_hit),
      .rs_valid      (rs_valid),
      .rs_taken      (rs_taken),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .pend_count    (pend_count),
      .err_underflow (err_underflow)
   );

   if_branch_predictor #(.PRED_MODE(0)) dut_s (
      .clk           (clk),
      .reset_n       (reset_n),
      .lu_valid      (lu_valid),
      .lu_pc         (lu_pc),
      .lu_imme       (lu_imme),
      .lu_ready      (lu_ready_s),
      .pred_taken    (pred_taken_s),
      .pred_target   (pred_target_s),
      .pred_hit      (pred_hit_s),
      .rs_valid      (rs_valid),
      .rs_taken      (rs_taken),
      .mispredict    (mispredict_s),
      .redirect_pc   (redirect_pc_s),
      .pend_count    (pend_count_s),
      .err_underflow (err_underflow_s)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned midx(input logic [31:0] pc);
      return (pc >> 2) % 1024;
   endfunction

   function automatic bit mhit(input logic [31:0] pc);
      return m_v[midx(pc)] && (m_tag[midx(pc)] == (pc >> 12));
   endfunction

   function automatic bit mpred(input logic [31:0] pc);
      if (!mhit(pc)) return 1'b1;
      return m_c[midx(pc)] >= 2;
   endfunction

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < 1024; i++) m_v[i] = 1'b0;
      m_err = 1'b0;
      e_mis = 1'b0;
      e_red = '0;
   endtask

   task automatic do_reset();
      lu_valid = 1'b0;
      rs_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      model_reset();
      chk("rst_pend", pend_count, 0);
      chk("rst_mis", mispredict, 0);
      chk("rst_red", redirect_pc, 0);
      chk("rst_err", err_underflow, 0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic peek(input logic [31:0] pc, input string tag,
                       input bit ehit, input bit etk);
      lu_valid = 1'b0;
      rs_valid = 1'b0;
      lu_pc    = pc;
      lu_imme  = 32'h40;
      #1;
      chk({tag, "_hit"}, pred_hit, ehit);
      chk({tag, "_tk"}, pred_taken, etk);
      @(negedge clk);
      e_mis = 1'b0;
   endtask

   task automatic step(input bit lv, input logic [31:0] pc,
                       input logic [31:0] imm, input bit rv,
                       input bit rt);
      bit          hit, pt, pop, mis, rdy;
      int unsigned i;
      ent_t        h;
      lu_valid = lv;
      lu_pc    = pc;
      lu_imme  = imm;
      rs_valid = rv;
      rs_taken = rt;
      #1;
      hit = mhit(pc);
      pt  = mpred(pc);
      pop = rv && (m_q.size() > 0);
      mis = 1'b0;
      if (pop) mis = (rt != m_q[0].pt);
      rdy = (m_q.size() < 4) || (pop && !mis);
      chk("hit", pred_hit, hit);
      chk("taken", pred_taken, pt);
      chk("target", pred_target, pt ? pc + imm : pc + 32'd4);
      chk("ready", lu_ready, rdy);
      chk("s_taken", pred_taken_s, 1);
      chk("s_hit", pred_hit_s, 0);
      if (rv && m_q.size() == 0) m_err = 1'b1;
      e_mis = mis;
      if (pop) begin
         h = m_q[0];
         i = midx(h.pc);
         if (mis) e_red = rt ? h.pc + h.imm : h.pc + 32'd4;
         if (mhit(h.pc)) begin
            if (rt) m_c[i] = (m_c[i] == 3) ? 3 : m_c[i] + 1;
            else    m_c[i] = (m_c[i] == 0) ? 0 : m_c[i] - 1;
         end else begin
            m_v[i]   = 1'b1;
            m_tag[i] = h.pc >> 12;
            m_c[i]   = rt ? 2 : 1;
         end
         if (mis) m_q.delete();
         else     void'(m_q.pop_front());
      end
      if (lv && rdy && !mis) m_q.push_back('{pc, imm, pt});
      @(posedge clk);
      @(negedge clk);
      chk("mispredict", mispredict, e_mis);
      if (e_mis) chk("redirect", redirect_pc, e_red);
      chk("pend_count", pend_count, m_q.size());
      chk("err_uf", err_underflow, m_err);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] pc;
      reset_n  = 1'b0;
      lu_valid = 1'b0;
      rs_valid = 1'b0;
      rs_taken = 1'b0;
      lu_pc    = '0;
      lu_imme  = '0;
      @(negedge clk);
      do_reset();

      // cold miss predicted taken, resolved not-taken
      step(1, 32'h100, 32'h40, 0, 0);
      chk("t1_tgt", pred_target, 32'h140);
      step(0, 32'h0, 32'h0, 1, 0);
      chk("t1_mis", mispredict, 1);
      chk("t1_red", redirect_pc, 32'h104);
      peek(32'h100, "t1", 1, 0);

      // saturation: five taken, then one not-taken
      step(1, 32'h200, 32'h10, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(k < 4, 32'h200, 32'h10, 1, 1);
         chk("t2_nomis", mispredict, 0);
      end
      step(1, 32'h200, 32'h10, 0, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      chk("t2_mis1", mispredict, 1);
      peek(32'h200, "t2", 1, 1);

      // aliasing on the same index
      do_reset();
      step(1, 32'h1000, 32'h4, 0, 0);
      step(0, 32'h0, 32'h0, 1, 1);
      peek(32'h2000, "t3a", 0, 1);
      step(1, 32'h2000, 32'h8, 0, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      peek(32'h2000, "t3b", 1, 0);
      peek(32'h1000, "t3c", 0, 1);

      // full FIFO, push+pop while full, flush on mispredict
      do_reset();
      for (int k = 0; k < 4; k++) step(1, 32'h300, 32'h4, 0, 0);
      chk("t4_rdy", lu_ready, 0);
      step(1, 32'h304, 32'h4, 0, 0);
      chk("t4_ign", pend_count, 4);
      step(1, 32'h308, 32'h4, 1, 1);
      chk("t4_pp", pend_count, 4);
      step(1, 32'h30c, 32'h4, 1, 0);
      chk("t4_flush", pend_count, 0);
      chk("t4_mis", mispredict, 1);

      // underflow, then reset mid-stream
      do_reset();
      step(0, 32'h0, 32'h0, 1, 0);
      chk("t5_err", err_underflow, 1);
      step(1, 32'h500, 32'h4, 0, 0);
      step(1, 32'h504, 32'h4, 1, 1);
      step(1, 32'h508, 32'h4, 0, 0);
      do_reset();
      peek(32'h500, "t5", 0, 1);

      // static mode never learns
      for (int k = 0; k < 3; k++) begin
         step(1, 32'h400, 32'h4, 0, 0);
         step(0, 32'h0, 32'h0, 1, 0);
      end
      lu_pc = 32'h400;
      #1;
      chk("t6_s_tk", pred_taken_s, 1);
      chk("t6_s_hit", pred_hit_s, 0);
      chk("t6_m_tk", pred_taken, 0);
      @(negedge clk);
      e_mis = 1'b0;

      // random traffic over a small aliasing PC pool
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            pc = (32'($urandom_range(0, 7)) << 2) |
                 (32'($urandom_range(0, 3)) << 12) |
                 32'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 6, pc, $urandom(),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
